iot_seq: RTL and testbench
==========================

Name: iot_seq

Overview:
- Counter-based IOT (in-out transfer) timing sequencer. Replaces the hand-chained ldly1us/ldly1_5us/ldly2us instances with one controller.
- Sequence: init setup → T2 → final setup → T3A → reset → T4, plus a parallel restart interval that ends in T3.
- Generates the combined IOT drive level and its rising-edge strobe for the I/O bus.
- Sits between the instruction/IOT decode (start, abort) and the I/O bus drivers.

Parameters:
- INIT_CYC, 50, clk cycles of init-setup level (1 µs at 20 ns clk)
- FINAL_CYC, 75, clk cycles of final-setup level (1.5 µs)
- RESET_CYC, 100, clk cycles of reset level (2 µs)
- RESTART_CYC, 50, clk cycles of restart level (1 µs)
- CW, 8, counter width; must satisfy 2^CW > max of the four *_CYC values

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- iot_start  in  1  request; sampled every clk edge
- iot_abort  in  1  synchronous abort
- iot_init_setup  out  1  level
- iot_t2  out  1  one-cycle pulse
- iot_final_setup  out  1  level
- iot_t3a  out  1  one-cycle pulse
- iot_reset  out  1  level
- iot_t4  out  1  one-cycle pulse
- iot_restart  out  1  level
- iot_t3  out  1  one-cycle pulse
- iot_drive  out  1  iot_init_setup | iot_t2 | iot_final_setup
- drive_edge  out  1  iot_drive & ~(iot_drive registered one cycle)
- busy  out  1  high in any non-IDLE main state or while restart runs

Behaviour:
- Reset (reset=0, async): main FSM=IDLE, restart FSM=R_IDLE, counters=0, all outputs 0, drive history reg=0.
- All outputs are registered, except iot_drive and drive_edge, which are combinational from registers.
- Main FSM: IDLE → INIT → T2 → FINAL → T3A → RST → T4 → IDLE.
  - IDLE: if iot_start=1 and busy=0, go to INIT with counter=INIT_CYC-1.
  - INIT/FINAL/RST: the matching level output is high; counter decrements; on counter=0 go to the next pulse state.
  - T2/T3A/T4: exactly one cycle each, pulse output high.
  - T2 loads counter=FINAL_CYC-1 and enters FINAL.
  - T3A loads counter=RESET_CYC-1 and enters RST.
- Restart FSM (independent counter):
  - R_IDLE → R_RUN on the cycle the main FSM is in T2; load RESTART_CYC-1.
  - R_RUN: iot_restart=1; on counter=0 go to R_T3 (iot_t3=1 for one cycle), then R_IDLE.
- Latency with start high in cycle 0 and defaults:
  - init_setup cycles 1..50; t2 at 51
  - final_setup 52..126; t3a at 127
  - reset 128..227; t4 at 228
  - restart 52..101; t3 at 102
  - busy 1..228; back to 0 at 229
  - general: level length = *_CYC exactly; each pulse exactly 1 cycle.
- iot_start while busy=1: ignored, not queued. The cycle after T4/R_T3 clear busy may accept a new start.
- Start and idle restart in the same cycle: busy covers both FSMs, so a start is only accepted when both are idle.
- iot_abort=1 (any state): both FSMs go to idle and counters clear next cycle. No pulse is emitted in that cycle or after. Abort beats a simultaneous start.
- RESTART_CYC may exceed FINAL+RESET. The main FSM then parks in IDLE and busy stays high until R_T3 completes.
- *_CYC=1: level lasts one cycle; counter loads 0.
- drive_edge: iot_drive is continuous 1..126, so exactly one drive_edge per sequence, in cycle 1.

Test Plan:
- Nominal: reset released, start pulse at cycle 0 → init 1..50, t2@51, final 52..126, t3a@127, reset 128..227, t4@228, restart 52..101, t3@102, busy falls @229, single drive_edge@1.
- Start spam: start held high cycles 0..300 → second sequence's init_setup begins @230; no extra pulses in 0..229.
- Abort mid-FINAL: start@0, abort@80 → from cycle 81 all outputs 0, busy 0; no t3/t3a/t4 ever; new start@90 yields t2@141.
- Long restart (RESTART_CYC=200): start@0 → t4@228, busy stays 1 until t3@252, busy 0 @253; start@240 ignored.
- Async reset at cycle 60 (mid-FINAL, restart running), held 3 cycles → outputs 0 immediately without a clk edge, FSMs idle after release; start after release gives nominal timing.
- Minimum params (all *_CYC=1): start@0 → init@1, t2@2, final@3, t3a@4, reset@5, t4@6; restart@3, t3@4 (coincides with t3a).

Source files
------------

// File: rtl/iot_seq.sv
// iot_seq: counter-based IOT timing sequencer producing setup/reset levels,
// T2/T3A/T4 pulses, a parallel restart interval ending in T3, and the bus drive strobe.
module iot_seq #(
  parameter int INIT_CYC    = 50,
  parameter int FINAL_CYC   = 75,
  parameter int RESET_CYC   = 100,
  parameter int RESTART_CYC = 50,
  parameter int CW          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic iot_start,
  input  logic iot_abort,
  output logic iot_init_setup,
  output logic iot_t2,
  output logic iot_final_setup,
  output logic iot_t3a,
  output logic iot_reset,
  output logic iot_t4,
  output logic iot_restart,
  output logic iot_t3,
  output logic iot_drive,
  output logic drive_edge,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, INIT, T2, FINAL, T3A, RST, T4} state_e;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_T3} rstate_e;

  state_e        state_q, state_d;
  rstate_e       rstate_q, rstate_d;
  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic          init_q, init_d, t2_q, t2_d, final_q, final_d, t3a_q, t3a_d;
  logic          rlvl_q, rlvl_d, t4_q, t4_d, restart_q, restart_d, t3_q, t3_d;
  logic          busy_q, busy_d, drive_q, drive_d;
  logic          cnt_z, rcnt_z;

  assign cnt_z  = cnt_q == '0;
  assign rcnt_z = rcnt_q == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rstate_q  <= R_IDLE;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      init_q    <= 1'b0;
      t2_q      <= 1'b0;
      final_q   <= 1'b0;
      t3a_q     <= 1'b0;
      rlvl_q    <= 1'b0;
      t4_q      <= 1'b0;
      restart_q <= 1'b0;
      t3_q      <= 1'b0;
      busy_q    <= 1'b0;
      drive_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rstate_q  <= rstate_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      init_q    <= init_d;
      t2_q      <= t2_d;
      final_q   <= final_d;
      t3a_q     <= t3a_d;
      rlvl_q    <= rlvl_d;
      t4_q      <= t4_d;
      restart_q <= restart_d;
      t3_q      <= t3_d;
      busy_q    <= busy_d;
      drive_q   <= drive_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_z ? '0 : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (iot_start && !busy_q) begin
          state_d = INIT;
          cnt_d   = CW'(INIT_CYC - 1);
        end
      end
      INIT:  state_d = cnt_z ? T2 : INIT;
      T2: begin
        state_d = FINAL;
        cnt_d   = CW'(FINAL_CYC - 1);
      end
      FINAL: state_d = cnt_z ? T3A : FINAL;
      T3A: begin
        state_d = RST;
        cnt_d   = CW'(RESET_CYC - 1);
      end
      RST:   state_d = cnt_z ? T4 : RST;
      default: state_d = IDLE;
    endcase
    if (iot_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // restart interval is launched by the main FSM passing through T2
  always_comb begin
    rstate_d = rstate_q;
    rcnt_d   = rcnt_z ? '0 : rcnt_q - 1'b1;
    case (rstate_q)
      R_IDLE: if (state_q == T2) begin
        rstate_d = R_RUN;
        rcnt_d   = CW'(RESTART_CYC - 1);
      end
      R_RUN:   rstate_d = rcnt_z ? R_T3 : R_RUN;
      default: rstate_d = R_IDLE;
    endcase
    if (iot_abort) begin
      rstate_d = R_IDLE;
      rcnt_d   = '0;
    end
  end

  // outputs are registered from the next state so they align with the state itself
  always_comb begin
    init_d    = state_d == INIT;
    t2_d      = state_d == T2;
    final_d   = state_d == FINAL;
    t3a_d     = state_d == T3A;
    rlvl_d    = state_d == RST;
    t4_d      = state_d == T4;
    restart_d = rstate_d == R_RUN;
    t3_d      = rstate_d == R_T3;
    busy_d    = state_d != IDLE || rstate_d != R_IDLE;
    drive_d   = iot_drive;
  end

  assign iot_init_setup  = init_q;
  assign iot_t2          = t2_q;
  assign iot_final_setup = final_q;
  assign iot_t3a         = t3a_q;
  assign iot_reset       = rlvl_q;
  assign iot_t4          = t4_q;
  assign iot_restart     = restart_q;
  assign iot_t3          = t3_q;
  assign busy            = busy_q;
  assign iot_drive       = init_q | t2_q | final_q;
  assign drive_edge      = iot_drive & ~drive_q;
endmodule

// File: tb/tb_iot_seq.sv
// tb_iot_seq: directed checks of iot_seq timing for nominal, long-restart and minimum parameter sets.
module tb_iot_seq;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_n = 1'b0, abort_n = 1'b0;
  logic start_l = 1'b0, abort_l = 1'b0;
  logic start_m = 1'b0, abort_m = 1'b0;
  wire [10:0] v_nom, v_long, v_min;
  int n_chk = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;

  iot_seq u_nom (
    .clk(clk), .reset(reset), .iot_start(start_n), .iot_abort(abort_n),
    .iot_init_setup(v_nom[10]), .iot_t2(v_nom[9]), .iot_final_setup(v_nom[8]),
    .iot_t3a(v_nom[7]), .iot_reset(v_nom[6]), .iot_t4(v_nom[5]),
    .iot_restart(v_nom[4]), .iot_t3(v_nom[3]), .iot_drive(v_nom[2]),
    .drive_edge(v_nom[1]), .busy(v_nom[0])
  );

  iot_seq #(.RESTART_CYC(200)) u_long (
    .clk(clk), .reset(reset), .iot_start(start_l), .iot_abort(abort_l),
    .iot_init_setup(v_long[10]), .iot_t2(v_long[9]), .iot_final_setup(v_long[8]),
    .iot_t3a(v_long[7]), .iot_reset(v_long[6]), .iot_t4(v_long[5]),
    .iot_restart(v_long[4]), .iot_t3(v_long[3]), .iot_drive(v_long[2]),
    .drive_edge(v_long[1]), .busy(v_long[0])
  );

  iot_seq #(.INIT_CYC(1), .FINAL_CYC(1), .RESET_CYC(1), .RESTART_CYC(1)) u_min (
    .clk(clk), .reset(reset), .iot_start(start_m), .iot_abort(abort_m),
    .iot_init_setup(v_min[10]), .iot_t2(v_min[9]), .iot_final_setup(v_min[8]),
    .iot_t3a(v_min[7]), .iot_reset(v_min[6]), .iot_t4(v_min[5]),
    .iot_restart(v_min[4]), .iot_t3(v_min[3]), .iot_drive(v_min[2]),
    .drive_edge(v_min[1]), .busy(v_min[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected {init,t2,final,t3a,reset,t4,restart,t3,drive,edge,busy} at cycle c after a start in cycle 0
  function automatic logic [10:0] ev(input int c, input int i_end, input int t2, input int f_end,
                                     input int t3a, input int r_end, input int t4, input int s_end,
                                     input int t3, input int b_end);
    return {c >= 1 && c <= i_end, c == t2, c > t2 && c <= f_end, c == t3a,
            c > t3a && c <= r_end, c == t4, c > t2 && c <= s_end, c == t3,
            c >= 1 && c <= f_end, c == 1, c >= 1 && c <= b_end};
  endfunction

  function automatic logic [10:0] nom(input int c);
    return ev(c, 50, 51, 126, 127, 227, 228, 101, 102, 228);
  endfunction

  task automatic run_nom(input string tag);
    for (int c = 0; c <= 235; c++) begin
      cyc = c;
      start_n = (c == 0);
      chk(tag, 32'(v_nom), 32'(nom(c)));
      tick();
    end
    start_n = 1'b0;
  endtask

  initial begin
    #1;
    chk("reset_nom", 32'(v_nom), 32'h0);
    chk("reset_long", 32'(v_long), 32'h0);
    chk("reset_min", 32'(v_min), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_nom("nominal");

    for (int c = 0; c <= 300; c++) begin
      cyc = c;
      start_n = 1'b1;
      chk("spam", 32'(v_nom), 32'(c <= 229 ? nom(c) : nom(c - 229)));
      tick();
    end
    start_n = 1'b0;
    abort_n = 1'b1;
    tick();
    abort_n = 1'b0;
    cyc = 302;
    chk("spam_cleanup", 32'(v_nom), 32'h0);
    tick();

    for (int c = 0; c <= 150; c++) begin
      cyc = c;
      start_n = (c == 0 || c == 90);
      abort_n = (c == 80);
      chk("abort", 32'(v_nom), 32'(c <= 80 ? nom(c) : c <= 90 ? 11'h0 : nom(c - 90)));
      tick();
    end
    start_n = 1'b0;
    abort_n = 1'b1;
    tick();
    abort_n = 1'b0;
    chk("abort_cleanup", 32'(v_nom), 32'h0);
    tick();

    for (int c = 0; c <= 260; c++) begin
      cyc = c;
      start_l = (c == 0 || c == 240);
      chk("long_restart", 32'(v_long),
          32'(ev(c, 50, 51, 126, 127, 227, 228, 251, 252, 252)));
      tick();
    end
    start_l = 1'b0;

    for (int c = 0; c <= 60; c++) begin
      cyc = c;
      start_n = (c == 0);
      chk("pre_areset", 32'(v_nom), 32'(nom(c)));
      if (c < 60) tick();
    end
    #1;
    reset = 1'b0;
    #1;
    chk("areset_immediate", 32'(v_nom), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("areset_held", 32'(v_nom), 32'h0);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("areset_idle", 32'(v_nom), 32'h0);
    end
    run_nom("after_areset");

    for (int c = 0; c <= 10; c++) begin
      cyc = c;
      start_m = (c == 0);
      chk("min_params", 32'(v_min), 32'(ev(c, 1, 2, 3, 4, 5, 6, 3, 4, 6)));
      tick();
    end
    start_m = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
